imem_resp: RTL and testbench

Instruction-memory responder for the fetch stage. Accepts fetch requests over a valid/ready channel, reads a word-addressed instruction array, and returns each 32-bit instruction in request order after a fixed latency, through a small response FIFO that absorbs fetch backpressure. It sits beside `core`, serving the fetch port. It also provides a backdoor write port so benches and boot logic can preload the program.

---
 rtl/instr.sv | 14 +
 rtl/imem_resp_fifo.sv | 61 ++++++
 rtl/imem_resp.sv | 129 ++++++++++++
 tb/tb_imem_resp.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr.sv
// Shared fetch-side types: raw instruction word, the imem response record and
// the default responder latency.
package instr;

  typedef logic [31:0] t_rv_instr;

  typedef struct packed {
    t_rv_instr instr;
    logic      fault;
  } t_imem_resp;

  localparam int IMEM_LATENCY_DEFAULT = 2;

endpackage

// File: rtl/imem_resp_fifo.sv
// Small synchronous FIFO with a flush input and a zeroed head when empty,
// reusable by any fetch/mem-side buffer that carries a packed payload.
module imem_resp_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [31:0]
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush_i,
  input  logic push_i,
  input  T     data_i,
  input  logic pop_i,
  output T     data_o,
  output logic empty_o,
  output logic full_o
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  T              mem_q [DEPTH];
  logic [IW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic          push_ok, pop_ok;

  function automatic logic [IW-1:0] ptr_inc(input logic [IW-1:0] p);
    return (p == IW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) wr_q <= ptr_inc(wr_q);
      if (pop_ok)  rd_q <= ptr_inc(rd_q);
      cnt_q <= cnt_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  // NOTE: storage has no reset; occupancy lives in the pointers/count, and a
  // reset-free array maps onto plain RAM/flops without reset routing.
  always_ff @(posedge clk) begin
    if (push_ok && !flush_i) mem_q[wr_q] <= data_i;
  end

  assign data_o = empty_o ? '0 : mem_q[rd_q];

endmodule

// File: rtl/imem_resp.sv
// Fetch-side instruction memory responder: credit-limited requests, fixed
// latency read pipe, in-order response FIFO. Optional: IMEM_MISALIGN_FAULT_EN.
module imem_resp
  import instr::*;
#(
  parameter int DEPTH_WORDS     = 1024,
  parameter int LATENCY         = IMEM_LATENCY_DEFAULT,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid_fe,
  output logic        req_ready_fe,
  input  logic [31:0] req_addr_fe,
  output logic        resp_valid_fe,
  input  logic        resp_ready_fe,
  output logic [31:0] resp_instr_fe,
  output logic        resp_fault_fe,
  input  logic        flush_fe,
  input  logic        ld_en,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data
);

  localparam int            AW          = $clog2(DEPTH_WORDS);
  localparam int            CW          = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [CW-1:0] CREDITS_MAX = CW'(MAX_OUTSTANDING);

  t_rv_instr     mem_q [DEPTH_WORDS];
  logic [CW-1:0] credits_q, credits_d;
  logic          run_q;
  logic          accept, pop, push;
  logic          fifo_empty, fifo_full;
  logic [AW-1:0] rd_idx, ld_idx;
  t_imem_resp    rd_resp, push_data, head;
  logic          unused_ok;

  assign rd_idx       = req_addr_fe[2 +: AW];
  assign ld_idx       = ld_addr[2 +: AW];
  assign req_ready_fe = run_q & ~flush_fe & (credits_q != '0);
  assign accept       = req_valid_fe & req_ready_fe;
  assign pop          = resp_valid_fe & resp_ready_fe;

  // NOTE: default first so every path assigns credits_d and no latch is inferred.
  always_comb begin
    credits_d = credits_q;
    if (flush_fe)             credits_d = CREDITS_MAX;
    else if (accept && !pop)  credits_d = credits_q - 1'b1;
    else if (pop && !accept)  credits_d = credits_q + 1'b1;
  end

  // run_q holds ready low during reset and releases it one edge later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      credits_q <= CREDITS_MAX;
      run_q     <= 1'b0;
    end else begin
      credits_q <= credits_d;
      run_q     <= 1'b1;
    end
  end

  // Combinational read plus edge write gives read-first on a collision.
  always_ff @(posedge clk) begin
    if (ld_en) mem_q[ld_idx] <= ld_data;
  end

`ifdef IMEM_MISALIGN_FAULT_EN
  logic addr_fault;
  assign addr_fault     = (req_addr_fe[1:0] != 2'b00) | (req_addr_fe[31:2+AW] != '0);
  assign rd_resp.instr  = addr_fault ? '0 : mem_q[rd_idx];
  assign rd_resp.fault  = addr_fault;
  assign resp_fault_fe  = head.fault;
  assign unused_ok      = ^{ld_addr[31:2+AW], ld_addr[1:0], fifo_full};
`else
  assign rd_resp.instr  = mem_q[rd_idx];
  assign rd_resp.fault  = 1'b0;
  assign resp_fault_fe  = 1'b0;
  assign unused_ok      = ^{req_addr_fe[31:2+AW], req_addr_fe[1:0],
                            ld_addr[31:2+AW], ld_addr[1:0], fifo_full, head.fault};
`endif

  if (LATENCY == 1) begin : g_nopipe
    assign push      = accept;
    assign push_data = rd_resp;
  end else begin : g_pipe
    localparam int S = LATENCY - 1;
    logic [S-1:0] v_q;
    t_imem_resp   d_q [S];

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        v_q <= '0;
      end else if (flush_fe) begin
        v_q <= '0;
      end else begin
        v_q[0] <= accept;
        for (int i = 1; i < S; i++) v_q[i] <= v_q[i-1];
      end
    end

    always_ff @(posedge clk) begin
      d_q[0] <= rd_resp;
      for (int i = 1; i < S; i++) d_q[i] <= d_q[i-1];
    end

    assign push      = v_q[S-1];
    assign push_data = d_q[S-1];
  end

  imem_resp_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .T     (t_imem_resp)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .flush_i (flush_fe),
    .push_i  (push),
    .data_i  (push_data),
    .pop_i   (pop),
    .data_o  (head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign resp_valid_fe = ~fifo_empty;
  assign resp_instr_fe = head.instr;

endmodule

// File: tb/tb_imem_resp.sv
// Scoreboard bench for imem_resp: stimulus pushes expected responses, a
// negedge monitor pops and compares on every accepted response.
module tb_imem_resp;
  import instr::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid_fe, req_ready_fe;
  logic [31:0] req_addr_fe;
  logic        resp_valid_fe, resp_ready_fe;
  logic [31:0] resp_instr_fe;
  logic        resp_fault_fe;
  logic        flush_fe;
  logic        ld_en;
  logic [31:0] ld_addr, ld_data;

  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          last_acc = 0;
  t_imem_resp  exp_q[$];
  int          pop_cyc_q[$];

  logic [31:0] vec_addr [4] = '{32'h14, 32'h18, 32'h1C, 32'h20};
  logic [31:0] vec_data [4] = '{32'h00500093, 32'h00100113, 32'h00208193, 32'h40208233};

  imem_resp dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid_fe  (req_valid_fe),
    .req_ready_fe  (req_ready_fe),
    .req_addr_fe   (req_addr_fe),
    .resp_valid_fe (resp_valid_fe),
    .resp_ready_fe (resp_ready_fe),
    .resp_instr_fe (resp_instr_fe),
    .resp_fault_fe (resp_fault_fe),
    .flush_fe      (flush_fe),
    .ld_en         (ld_en),
    .ld_addr       (ld_addr),
    .ld_data       (ld_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every response actually consumed must match the queue head.
  initial begin
    t_imem_resp e;
    forever begin
      @(negedge clk);
      if (reset && !flush_fe && resp_valid_fe && resp_ready_fe) begin
        if (exp_q.size() == 0) begin
          check("unexpected_resp", resp_instr_fe, 32'hxxxxxxxx);
        end else begin
          e = exp_q.pop_front();
          check("resp_instr", resp_instr_fe, e.instr);
          check("resp_fault", 32'(resp_fault_fe), 32'(e.fault));
          pop_cyc_q.push_back(cyc);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] addr, input logic [31:0] data);
    ld_en = 1'b1; ld_addr = addr; ld_data = data;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic send(input logic [31:0] addr, input logic [31:0] instr_v, input logic fault_v);
    bit done = 1'b0;
    req_valid_fe = 1'b1;
    req_addr_fe  = addr;
    for (int t = 0; t < 20 && !done; t++) begin
      @(negedge clk);
      if (req_ready_fe) begin
        exp_q.push_back('{instr: instr_v, fault: fault_v});
        last_acc = cyc;
        done = 1'b1;
      end
      tick();
    end
    req_valid_fe = 1'b0;
    check("send_accepted", 32'(done), 32'd1);
  endtask

  task automatic burst(input int n, output int acc);
    acc = 0;
    for (int k = 0; k < n; k++) begin
      req_valid_fe = 1'b1;
      req_addr_fe  = vec_addr[acc % 4];
      @(negedge clk);
      if (req_ready_fe) begin
        exp_q.push_back('{instr: vec_data[acc % 4], fault: 1'b0});
        acc++;
      end
      tick();
    end
    req_valid_fe = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 50 && exp_q.size() != 0; t++) @(negedge clk);
    check("drain_empty", exp_q.size(), 32'd0);
    tick();
  endtask

  initial begin
    int a0, acc, flush_cyc;
    reset = 1'b0; req_valid_fe = 1'b0; req_addr_fe = '0; resp_ready_fe = 1'b1;
    flush_fe = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(req_ready_fe), 32'd0);
    check("rst_valid", 32'(resp_valid_fe), 32'd0);
    check("rst_instr", resp_instr_fe, 32'd0);
    check("rst_fault", 32'(resp_fault_fe), 32'd0);
    tick();
    reset = 1'b1;
    @(negedge clk);
    check("ready_deassert_cycle", 32'(req_ready_fe), 32'd0);
    tick();
    @(negedge clk);
    check("ready_after_reset", 32'(req_ready_fe), 32'd1);
    tick();

    for (int i = 0; i < 4; i++) load(vec_addr[i], vec_data[i]);

    // Basic back-to-back reads and latency
    pop_cyc_q.delete();
    send(32'h14, 32'h00500093, 1'b0);
    a0 = last_acc;
    send(32'h18, 32'h00100113, 1'b0);
    check("b2b_accept", 32'(last_acc), 32'(a0 + 1));
    drain();
    check("basic_pops", pop_cyc_q.size(), 32'd2);
    check("lat_first", 32'(pop_cyc_q[0]), 32'(a0 + 2));
    check("lat_second", 32'(pop_cyc_q[1]), 32'(a0 + 3));

    // Backpressure: 6 offered, 4 accepted, head held, credit returns after pop
    resp_ready_fe = 1'b0;
    pop_cyc_q.delete();
    burst(6, acc);
    check("bp_accepted", 32'(acc), 32'd4);
    @(negedge clk);
    check("bp_ready_low", 32'(req_ready_fe), 32'd0);
    check("bp_valid", 32'(resp_valid_fe), 32'd1);
    check("bp_head", resp_instr_fe, 32'h00500093);
    tick();
    @(negedge clk);
    check("bp_head_stable", resp_instr_fe, 32'h00500093);
    tick();
    resp_ready_fe = 1'b1;
    @(negedge clk);
    check("bp_ready_pop_cycle", 32'(req_ready_fe), 32'd0);
    tick();
    @(negedge clk);
    check("bp_ready_after_pop", 32'(req_ready_fe), 32'd1);
    tick();
    drain();
    check("bp_pops", pop_cyc_q.size(), 32'd4);

    // Flush with responses pending and one request in the pipe
    resp_ready_fe = 1'b0;
    send(32'h14, 32'h00500093, 1'b0);
    tick();
    send(32'h18, 32'h00100113, 1'b0);
    send(32'h1C, 32'h00208193, 1'b0);
    send(32'h20, 32'h40208233, 1'b0);
    flush_fe = 1'b1;
    resp_ready_fe = 1'b1;
    exp_q.delete();
    pop_cyc_q.delete();
    @(negedge clk);
    flush_cyc = cyc;
    tick();
    flush_fe = 1'b0;
    send(32'h14, 32'h00500093, 1'b0);
    check("flush_next_accept", 32'(last_acc), 32'(flush_cyc + 1));
    drain();
    check("flush_pops", pop_cyc_q.size(), 32'd1);
    check("flush_resp_cycle", 32'(pop_cyc_q[0]), 32'(flush_cyc + 3));
    resp_ready_fe = 1'b0;
    burst(5, acc);
    check("flush_credits", 32'(acc), 32'd4);
    resp_ready_fe = 1'b1;
    drain();

    // Address wrap: upper bits ignored (faulted when the fault option is on)
`ifdef IMEM_MISALIGN_FAULT_EN
    send(32'h1014, 32'h0, 1'b1);
`else
    send(32'h1014, 32'h00500093, 1'b0);
`endif
    drain();

    // Read-first collision, then the new value
    ld_en = 1'b1; ld_addr = 32'h14; ld_data = 32'hDEADBEEF;
    send(32'h14, 32'h00500093, 1'b0);
    ld_en = 1'b0;
    send(32'h14, 32'hDEADBEEF, 1'b0);
    drain();

`ifdef IMEM_MISALIGN_FAULT_EN
    send(32'h16, 32'h0, 1'b1);
    send(32'h18, 32'h00100113, 1'b0);
    drain();
`endif

    // Reset mid-stream: outputs drop at once, nothing stale afterwards
    resp_ready_fe = 1'b0;
    send(32'h14, 32'hDEADBEEF, 1'b0);
    send(32'h18, 32'h00100113, 1'b0);
    @(negedge clk);
    check("mid_valid_before", 32'(resp_valid_fe), 32'd1);
    tick();
    reset = 1'b0;
    #1;
    check("mid_rst_valid", 32'(resp_valid_fe), 32'd0);
    check("mid_rst_instr", resp_instr_fe, 32'd0);
    check("mid_rst_fault", 32'(resp_fault_fe), 32'd0);
    check("mid_rst_ready", 32'(req_ready_fe), 32'd0);
    exp_q.delete();
    repeat (2) tick();
    reset = 1'b1;
    tick();
    @(negedge clk);
    check("mid_ready_after", 32'(req_ready_fe), 32'd1);
    tick();
    resp_ready_fe = 1'b1;
    pop_cyc_q.delete();
    send(32'h18, 32'h00100113, 1'b0);
    drain();
    check("mid_pops", pop_cyc_q.size(), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
